// File: rtl/udma_hyper_pkg.sv
// Shared types for the HyperBus uDMA datapath.
// TX fetch FSM encoding lives here so benches and peers can decode it.
package udma_hyper_pkg;

    typedef enum logic [1:0] {
        TXF_IDLE,
        TXF_FETCH,
        TXF_FLUSH,
        TXF_DONE
    } txfetch_state_e;

endpackage

// File: rtl/udma_hyper_txfetch_fifo.sv
// Word FIFO for the TX fetch path: registered storage, head visible
// as soon as a word is stored, synchronous flush.
module udma_hyper_txfetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [CW-1:0]         count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_q;
    logic [AW-1:0]         rd_q;
    logic [CW-1:0]         cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // A pop at full frees the slot the simultaneous push lands in.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy; flush drops all entries at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Upstream credit throttling must never push into a full FIFO.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/udma_hyper_txfetch.sv
// HyperBus TX fetch: pulls words from the uDMA TX channel under credit
// control and hands them downstream with a live remaining-byte count.
module udma_hyper_txfetch
    import udma_hyper_pkg::*;
#(
    parameter int TRANS_SIZE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [TRANS_SIZE-1:0] trans_size_i,
    input  logic                  abort_i,
    output logic                  tx_req_o,
    input  logic                  tx_gnt_i,
    input  logic                  tx_valid_i,
    input  logic [31:0]           tx_data_i,
    output logic                  tx_ready_o,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [31:0]           data_o,
    output logic [TRANS_SIZE-1:0] remained_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    txfetch_state_e        state_q, state_d;
    logic [TRANS_SIZE:0]   req_left_q, req_left_d;
    logic [CW-1:0]         out_q, out_d;
    logic [TRANS_SIZE-1:0] rem_q, rem_d;

    logic [TRANS_SIZE:0]   words_total;
    logic [CW:0]           inflight;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fetch;
    logic                  grant;
    logic                  resp;
    logic                  pop;
    logic                  push;
    logic                  flush;
    logic                  last_pop;
    logic [TRANS_SIZE-1:0] step;

    // Extra bit keeps size+3 from wrapping at the maximum size.
    assign words_total = ({1'b0, trans_size_i} + (TRANS_SIZE+1)'(3)) >> 2;

    assign fetch    = (state_q == TXF_FETCH);
    assign busy_o   = fetch || (state_q == TXF_FLUSH);
    assign done_o   = (state_q == TXF_DONE);
    assign tx_ready_o = busy_o;
    assign remained_o = rem_q;

    // Words in flight plus words held never exceed the FIFO depth.
    assign inflight = {1'b0, out_q} + {1'b0, fifo_cnt};
    assign tx_req_o = fetch && (req_left_q != '0) && !fifo_full
                   && (inflight < (CW+1)'(FIFO_DEPTH));

    assign grant    = tx_req_o && tx_gnt_i;
    assign resp     = tx_valid_i && busy_o;
    assign dst_valid_o = fetch && !fifo_empty;
    assign pop      = dst_valid_o && dst_ready_i;
    assign flush    = fetch && abort_i;
    assign push     = fetch && tx_valid_i && !abort_i;

    assign step     = (rem_q > TRANS_SIZE'(4)) ? TRANS_SIZE'(4) : rem_q;
    assign last_pop = pop && (rem_q <= TRANS_SIZE'(4));

    udma_hyper_txfetch_fifo #(
        .DATA_WIDTH(32),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .data_i (tx_data_i),
        .pop_i  (pop),
        .flush_i(flush),
        .data_o (data_o),
        .empty_o(fifo_empty),
        .full_o (fifo_full),
        .count_o(fifo_cnt)
    );

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TXF_IDLE;
            req_left_q <= '0;
            out_q      <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_left_q <= req_left_d;
            out_q      <= out_d;
            rem_q      <= rem_d;
        end
    end

    // Next state, request budget, outstanding count and byte countdown.
    always_comb begin
        state_d    = state_q;
        req_left_d = req_left_q;
        rem_d      = rem_q;

        unique case ({grant, resp})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        unique case (state_q)
            TXF_IDLE: begin
                if (start_i) begin
                    rem_d      = trans_size_i;
                    req_left_d = words_total;
                    state_d    = (trans_size_i != '0) ? TXF_FETCH : TXF_DONE;
                end
            end
            TXF_FETCH: begin
                if (grant) begin
                    req_left_d = req_left_q - (TRANS_SIZE+1)'(1);
                end
                if (pop) begin
                    rem_d = rem_q - step;
                end
                if (abort_i) begin
                    state_d    = TXF_FLUSH;
                    rem_d      = '0;
                    req_left_d = '0;
                end else if (last_pop) begin
                    state_d = TXF_DONE;
                end
            end
            TXF_FLUSH: begin
                if (out_q == '0) begin
                    state_d = TXF_DONE;
                end
            end
            TXF_DONE: begin
                state_d = TXF_IDLE;
            end
            default: begin
                state_d = TXF_IDLE;
            end
        endcase
    end

endmodule
